// File: rtl/colordetect_pkg.sv
// Shared widths, reset defaults and state encoding for the ColorDetect pipeline.
package colordetect_pkg;

    localparam int H_W        = 12;
    localparam int V_W        = 11;
    localparam int WEIGHT_W   = 4;
    localparam int INIT_H_DEF = 320;
    localparam int INIT_V_DEF = 240;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_OUT
    } track_state_t;

endpackage

// File: rtl/centroid_track_if.sv
// Video timing, pixel weight and tracked-centre signals between the weighting stage and centroid_track.
interface centroid_track_if;
    import colordetect_pkg::*;

    logic [H_W-1:0]      VtcHCnt;
    logic [V_W-1:0]      VtcVCnt;
    logic                VtcVde;
    logic                VtcVs;
    logic                match;
    logic [WEIGHT_W-1:0] weight;
    logic [H_W-1:0]      center_h;
    logic [V_W-1:0]      center_v;
    logic                found;
    logic                valid;

    modport master (
        output VtcHCnt, VtcVCnt, VtcVde, VtcVs, match, weight,
        input  center_h, center_v, found, valid
    );

    modport slave (
        input  VtcHCnt, VtcVCnt, VtcVde, VtcVs, match, weight,
        output center_h, center_v, found, valid
    );

endinterface

// File: rtl/seq_div.sv
// Unsigned restoring divider, one quotient bit per clock; operands are captured on start.
module seq_div #(
    parameter int N = 38,
    parameter int D = 26,
    parameter int Q = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [D-1:0] divisor,
    output logic [Q-1:0] quotient,
    output logic         done,
    output logic         busy
);
    localparam int CW = $clog2(N + 1);

    logic [D-1:0]  rem;
    logic [N-1:0]  quo;
    logic [D-1:0]  dsr;
    logic [CW-1:0] count;
    logic [D:0]    shifted;
    logic          fits;

    // quo starts as the dividend and is shifted left, quotient bits entering at the bottom
    assign shifted = {rem, quo[N-1]};
    assign fits    = shifted >= {1'b0, dsr};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem   <= '0;
            quo   <= '0;
            dsr   <= '0;
            count <= '0;
        end else if (start) begin
            rem   <= '0;
            quo   <= dividend;
            dsr   <= divisor;
            count <= CW'(N);
        end else if (busy) begin
            count <= count - CW'(1);
            rem   <= fits ? D'(shifted - {1'b0, dsr}) : shifted[D-1:0];
            quo   <= {quo[N-2:0], fits};
        end
    end

    // done flags the cycle whose closing edge writes the final quotient bit
    assign busy     = (count != '0);
    assign done     = (count == CW'(1));
    assign quotient = quo[Q-1:0];

endmodule

// File: rtl/centroid_track.sv
// Accumulates weighted pixel coordinates over a frame and divides at each vsync edge
// to produce the tracked centre fed back to the weighting stage.
module centroid_track
    import colordetect_pkg::*;
#(
    parameter int SUM_W  = 26,
    parameter int INIT_H = INIT_H_DEF,
    parameter int INIT_V = INIT_V_DEF,
    parameter int MIN_W  = 64,
    parameter bit VS_POL = 1'b1
) (
    input  logic PCLK,
    input  logic RST_N,
    centroid_track_if.slave vid
);
    localparam int XW = SUM_W + H_W;
    localparam int YW = SUM_W + V_W;
    localparam logic [SUM_W-1:0] MIN_SUM = SUM_W'(MIN_W);

    logic [H_W-1:0]   h_d;
    logic [V_W-1:0]   v_d;
    logic             vde_d;
    logic             match_d;
    logic             vs_q;
    logic             vs_prev;
    logic [SUM_W-1:0] acc_w;
    logic [XW-1:0]    acc_x;
    logic [YW-1:0]    acc_y;
    logic [SUM_W-1:0] w_term;
    logic [XW-1:0]    x_term;
    logic [YW-1:0]    y_term;
    logic             pix_ok;
    logic             frame_edge;
    logic             div_go;
    logic             busy_x;
    logic             busy_y;
    logic             done_x;
    logic             done_y;
    logic [H_W-1:0]   quo_x;
    logic [V_W-1:0]   quo_y;
    track_state_t     state;
    logic             divided;

    // Timing and match are pushed one stage so they line up with the registered weight
    always_ff @(posedge PCLK or negedge RST_N) begin
        if (!RST_N) begin
            h_d     <= '0;
            v_d     <= '0;
            vde_d   <= 1'b0;
            match_d <= 1'b0;
            vs_q    <= 1'b0;
            vs_prev <= 1'b0;
        end else begin
            h_d     <= vid.VtcHCnt;
            v_d     <= vid.VtcVCnt;
            vde_d   <= vid.VtcVde;
            match_d <= vid.match;
            vs_q    <= vid.VtcVs;
            vs_prev <= vs_q;
        end
    end

    assign pix_ok     = vde_d & match_d;
    assign frame_edge = (vs_q == VS_POL) && (vs_prev != VS_POL);
    assign w_term     = SUM_W'(vid.weight);
    assign x_term     = XW'(vid.weight) * XW'(h_d);
    assign y_term     = YW'(vid.weight) * YW'(v_d);

    // On the edge cycle the old sums go to the dividers and any pixel starts the new frame
    always_ff @(posedge PCLK or negedge RST_N) begin
        if (!RST_N) begin
            acc_w <= '0;
            acc_x <= '0;
            acc_y <= '0;
        end else if (frame_edge) begin
            acc_w <= pix_ok ? w_term : '0;
            acc_x <= pix_ok ? x_term : '0;
            acc_y <= pix_ok ? y_term : '0;
        end else if (pix_ok) begin
            acc_w <= acc_w + w_term;
            acc_x <= acc_x + x_term;
            acc_y <= acc_y + y_term;
        end
    end

    assign div_go = (state == S_IDLE) && frame_edge && (acc_w >= MIN_SUM) && !(busy_x || busy_y);

    // Both dividers use the same dividend width so they finish on the same cycle
    seq_div #(.N(XW), .D(SUM_W), .Q(H_W)) u_div_x (
        .clk      (PCLK),
        .rst_n    (RST_N),
        .start    (div_go),
        .dividend (acc_x),
        .divisor  (acc_w),
        .quotient (quo_x),
        .done     (done_x),
        .busy     (busy_x)
    );

    seq_div #(.N(XW), .D(SUM_W), .Q(V_W)) u_div_y (
        .clk      (PCLK),
        .rst_n    (RST_N),
        .start    (div_go),
        .dividend (XW'(acc_y)),
        .divisor  (acc_w),
        .quotient (quo_y),
        .done     (done_y),
        .busy     (busy_y)
    );

    // Edges arriving outside S_IDLE are ignored here; only the accumulators react to them
    always_ff @(posedge PCLK or negedge RST_N) begin
        if (!RST_N) begin
            state        <= S_IDLE;
            divided      <= 1'b0;
            vid.valid    <= 1'b0;
            vid.found    <= 1'b0;
            vid.center_h <= H_W'(INIT_H);
            vid.center_v <= V_W'(INIT_V);
        end else begin
            vid.valid <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (frame_edge) begin
                        divided <= div_go;
                        state   <= div_go ? S_DIV : S_OUT;
                    end
                end
                S_DIV: begin
                    if (done_x && done_y) begin
                        state <= S_OUT;
                    end
                end
                S_OUT: begin
                    vid.valid <= 1'b1;
                    vid.found <= divided;
                    if (divided) begin
                        vid.center_h <= quo_x;
                        vid.center_v <= quo_y;
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_centroid_track.sv
// Directed bench for centroid_track: a frame-sum model pushes expected centres at each
// vsync edge and they are popped when the DUT pulses valid.
module tb_centroid_track;
    import colordetect_pkg::*;

    localparam int SUM_W    = 26;
    localparam int MIN_W    = 1;
    localparam int INIT_H   = 320;
    localparam int INIT_V   = 240;
    localparam int LAT_DIV  = SUM_W + 14;
    localparam int LAT_SKIP = 2;
    localparam int WAIT_MAX = 100;

    typedef struct {
        logic [H_W-1:0] h;
        logic [V_W-1:0] v;
        logic           found;
        int             lat;
    } expect_t;

    expect_t exp_q[$];

    logic PCLK  = 1'b0;
    logic RST_N = 1'b0;

    int total      = 0;
    int bad        = 0;
    int since_edge = 0;
    int pulses     = 0;

    logic           vs_level  = 1'b0;
    logic [3:0]     pending_w = '0;
    longint unsigned sum_w = 0;
    longint unsigned sum_x = 0;
    longint unsigned sum_y = 0;
    logic [H_W-1:0] model_h = H_W'(INIT_H);
    logic [V_W-1:0] model_v = V_W'(INIT_V);

    centroid_track_if vid ();

    centroid_track #(
        .SUM_W  (SUM_W),
        .INIT_H (INIT_H),
        .INIT_V (INIT_V),
        .MIN_W  (MIN_W),
        .VS_POL (1'b1)
    ) dut (
        .PCLK  (PCLK),
        .RST_N (RST_N),
        .vid   (vid)
    );

    always #5 PCLK = ~PCLK;

    task automatic check_value(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // One pixel clock; the weight presented is the one for the previous step's pixel
    task automatic step(input logic [H_W-1:0] h, input logic [V_W-1:0] v,
                        input logic de, input logic m, input logic [3:0] w);
        vid.VtcHCnt = h;
        vid.VtcVCnt = v;
        vid.VtcVde  = de;
        vid.match   = m;
        vid.VtcVs   = vs_level;
        vid.weight  = pending_w;
        pending_w   = w;
        @(posedge PCLK);
        #1;
        since_edge++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, '0, 1'b0, 1'b0, 4'd0);
    endtask

    task automatic count_valid(input int n, output int seen);
        seen = 0;
        for (int i = 0; i < n; i++) begin
            idle(1);
            if (vid.valid === 1'b1) seen++;
        end
    endtask

    task automatic apply_stimulus(input logic [H_W-1:0] h, input logic [V_W-1:0] v, input logic [3:0] w);
        sum_w += 64'(w);
        sum_x += 64'(w) * 64'(h);
        sum_y += 64'(w) * 64'(v);
        step(h, v, 1'b1, 1'b1, w);
    endtask

    task automatic end_frame(input bit push, input bit with_pixel, input logic [H_W-1:0] h,
                             input logic [V_W-1:0] v, input logic [3:0] w);
        expect_t e;
        if (push) begin
            e.found = (sum_w >= 64'(MIN_W));
            if (e.found) begin
                model_h = H_W'(sum_x / sum_w);
                model_v = V_W'(sum_y / sum_w);
                e.lat   = LAT_DIV;
            end else begin
                e.lat   = LAT_SKIP;
            end
            e.h = model_h;
            e.v = model_v;
            exp_q.push_back(e);
        end
        sum_w = 0;
        sum_x = 0;
        sum_y = 0;
        vs_level = 1'b1;
        if (with_pixel) apply_stimulus(h, v, w);
        else idle(1);
        since_edge = 0;
    endtask

    task automatic check_output();
        expect_t e;
        int extra;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL scoreboard_empty: observed=0 entries expected=1");
            return;
        end
        e = exp_q.pop_front();
        while (vid.valid !== 1'b1 && since_edge < WAIT_MAX) idle(1);
        check_value("latency", 32'(since_edge), 32'(e.lat));
        check_value("center_h", 32'(vid.center_h), 32'(e.h));
        check_value("center_v", 32'(vid.center_v), 32'(e.v));
        check_value("found", 32'(vid.found), 32'(e.found));
        vs_level = 1'b0;
        count_valid(3, extra);
        check_value("single_pulse", 32'(extra), 32'd0);
    endtask

    initial begin
        vid.VtcHCnt = '0;
        vid.VtcVCnt = '0;
        vid.VtcVde  = 1'b0;
        vid.VtcVs   = 1'b0;
        vid.match   = 1'b0;
        vid.weight  = '0;

        #12;
        check_value("reset_center_h", 32'(vid.center_h), 32'(INIT_H));
        check_value("reset_center_v", 32'(vid.center_v), 32'(INIT_V));
        check_value("reset_found", 32'(vid.found), 32'd0);
        check_value("reset_valid", 32'(vid.valid), 32'd0);
        @(posedge PCLK);
        #1;
        RST_N = 1'b1;
        idle(3);

        // no qualified pixels: skip path, centre holds INIT
        step(12'd10, 11'd10, 1'b1, 1'b0, 4'd5);
        step(12'd11, 11'd10, 1'b0, 1'b1, 4'd7);
        idle(2);
        end_frame(1'b1, 1'b0, '0, '0, 4'd0);
        check_output();
        idle(3);

        apply_stimulus(12'd100, 11'd50, 4'd15);
        idle(2);
        end_frame(1'b1, 1'b0, '0, '0, 4'd0);
        check_output();
        idle(3);

        // two matched pixels with unqualified ones in between
        apply_stimulus(12'd100, 11'd50, 4'd15);
        step(12'd150, 11'd50, 1'b1, 1'b0, 4'd9);
        step(12'd160, 11'd50, 1'b0, 1'b1, 4'd9);
        apply_stimulus(12'd200, 11'd50, 4'd5);
        idle(2);
        end_frame(1'b1, 1'b0, '0, '0, 4'd0);
        check_output();
        idle(3);

        apply_stimulus(12'd10, 11'd7, 4'd1);
        apply_stimulus(12'd11, 11'd7, 4'd1);
        idle(2);
        end_frame(1'b1, 1'b0, '0, '0, 4'd0);
        check_output();
        idle(3);

        // frame weight exactly at the threshold
        apply_stimulus(12'd33, 11'd44, 4'd1);
        idle(2);
        end_frame(1'b1, 1'b0, '0, '0, 4'd0);
        check_output();
        idle(3);

        apply_stimulus(12'd4095, 11'd2047, 4'd15);
        idle(2);
        end_frame(1'b1, 1'b0, '0, '0, 4'd0);
        check_output();
        idle(3);

        // pixel on the snapshot cycle belongs to the following frame
        apply_stimulus(12'd300, 11'd200, 4'd8);
        idle(2);
        end_frame(1'b1, 1'b1, 12'd5, 11'd5, 4'd15);
        check_output();
        idle(3);
        end_frame(1'b1, 1'b0, '0, '0, 4'd0);
        check_output();
        idle(3);

        idle(2);
        end_frame(1'b1, 1'b0, '0, '0, 4'd0);
        check_output();
        idle(3);

        // second edge while dividing: discarded frame, no extra valid
        apply_stimulus(12'd50, 11'd60, 4'd4);
        idle(2);
        end_frame(1'b1, 1'b0, '0, '0, 4'd0);
        idle(10);
        vs_level = 1'b0;
        idle(4);
        apply_stimulus(12'd1, 11'd1, 4'd15);
        idle(1);
        sum_w = 0;
        sum_x = 0;
        sum_y = 0;
        vs_level = 1'b1;
        idle(1);
        check_output();
        count_valid(40, pulses);
        check_value("discard_no_valid", 32'(pulses), 32'd0);
        idle(2);
        apply_stimulus(12'd70, 11'd80, 4'd2);
        idle(2);
        end_frame(1'b1, 1'b0, '0, '0, 4'd0);
        check_output();
        idle(3);

        // reset in the middle of a division
        apply_stimulus(12'd400, 11'd300, 4'd10);
        idle(2);
        end_frame(1'b0, 1'b0, '0, '0, 4'd0);
        while (since_edge < 20) idle(1);
        RST_N       = 1'b0;
        vs_level    = 1'b0;
        vid.VtcVs   = 1'b0;
        pending_w   = '0;
        vid.weight  = '0;
        model_h     = H_W'(INIT_H);
        model_v     = V_W'(INIT_V);
        sum_w = 0;
        sum_x = 0;
        sum_y = 0;
        #1;
        check_value("midreset_center_h", 32'(vid.center_h), 32'(INIT_H));
        check_value("midreset_center_v", 32'(vid.center_v), 32'(INIT_V));
        check_value("midreset_found", 32'(vid.found), 32'd0);
        check_value("midreset_valid", 32'(vid.valid), 32'd0);
        idle(3);
        RST_N = 1'b1;
        count_valid(50, pulses);
        check_value("midreset_no_valid", 32'(pulses), 32'd0);
        apply_stimulus(12'd7, 11'd9, 4'd3);
        idle(2);
        end_frame(1'b1, 1'b0, '0, '0, 4'd0);
        check_output();
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
